// File: rtl/ddr_lane_dly_trainer.sv
// rtl/ddr_lane_dly_trainer.sv - sequential per-lane DQ/DQS delay-line eye-centring trainer
module ddr_lane_dly_trainer #(
    parameter int LANES         = 2,
    parameter int TAP_W         = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int MAX_AMBIG     = 3
) (
    input  logic                   fab_clk_i,
    input  logic                   arst_n_i,
    input  logic                   start_i,
    input  logic [LANES-1:0]       eye_monitor_early_i,
    input  logic [LANES-1:0]       eye_monitor_late_i,
    input  logic [LANES-1:0]       delay_line_out_of_range_i,
    output logic [LANES-1:0]       delay_line_load_o,
    output logic [LANES-1:0]       delay_line_move_o,
    output logic [LANES-1:0]       delay_line_direction_o,
    output logic [LANES-1:0]       eye_monitor_clear_flags_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [LANES-1:0]       lane_locked_o,
    output logic [LANES-1:0]       lane_err_o,
    output logic [LANES*TAP_W-1:0] tap_count_o
);

    localparam int              LW          = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [TAP_W-1:0] MAX_TAP    = '1;
    localparam logic [LW-1:0]   LAST_LANE   = LW'(LANES - 1);
    localparam logic [7:0]      SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0]      AMBIG_LIMIT = 8'(MAX_AMBIG);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_MOVE, S_NEXT
    } state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [7:0]             settle_q, settle_d;
    logic [7:0]             ambig_q, ambig_d;
    logic [LANES-1:0]       dir_q, dir_d;
    logic [LANES-1:0]       locked_q, locked_d;
    logic [LANES-1:0]       err_q, err_d;
    logic [LANES*TAP_W-1:0] tap_q, tap_d;

    int                     base;
    logic [TAP_W-1:0]       tap_cur;
    logic [LANES-1:0]       lane_sel;
    logic                   early, late, oor;

    // Current-lane views: tap slice, one-hot select and the three sampled flags
    assign base     = int'(lane_q) * TAP_W;
    assign tap_cur  = tap_q[base +: TAP_W];
    assign lane_sel = LANES'(1) << lane_q;
    assign early    = eye_monitor_early_i[lane_q];
    assign late     = eye_monitor_late_i[lane_q];
    assign oor      = delay_line_out_of_range_i[lane_q];

    assign busy_o                 = (state_q != S_IDLE);
    assign delay_line_direction_o = dir_q;
    assign lane_locked_o          = locked_q;
    assign lane_err_o             = err_q;
    assign tap_count_o            = tap_q;

    // State and datapath registers; reset discards any partial training result
    always_ff @(posedge fab_clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= S_IDLE;
            lane_q   <= '0;
            settle_q <= '0;
            ambig_q  <= '0;
            dir_q    <= '0;
            locked_q <= '0;
            err_q    <= '0;
            tap_q    <= '0;
        end else begin
            state_q  <= state_d;
            lane_q   <= lane_d;
            settle_q <= settle_d;
            ambig_q  <= ambig_d;
            dir_q    <= dir_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            tap_q    <= tap_d;
        end
    end

    // Next-state, per-lane result updates and state-decoded pulse outputs
    always_comb begin
        state_d  = state_q;
        lane_d   = lane_q;
        settle_d = settle_q;
        ambig_d  = ambig_q;
        dir_d    = dir_q;
        locked_d = locked_q;
        err_d    = err_q;
        tap_d    = tap_q;
        delay_line_load_o         = '0;
        delay_line_move_o         = '0;
        eye_monitor_clear_flags_o = '0;
        done_o                    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    locked_d = '0;
                    err_d    = '0;
                    tap_d    = '0;
                    lane_d   = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                delay_line_load_o        = lane_sel;
                tap_d[base +: TAP_W]     = '0;
                ambig_d                  = '0;
                state_d                  = S_CLEAR;
            end
            S_CLEAR: begin
                eye_monitor_clear_flags_o = lane_sel;
                settle_d                  = '0;
                state_d                   = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            S_SAMPLE: begin
                if (oor) begin
                    err_d[lane_q] = 1'b1;
                    state_d       = S_NEXT;
                end else if (!early && !late) begin
                    locked_d[lane_q] = 1'b1;
                    state_d          = S_NEXT;
                end else if (early && late) begin
                    // Ambiguous eye: retry without moving until the tolerance runs out
                    if ((ambig_q + 8'd1) >= AMBIG_LIMIT) begin
                        err_d[lane_q] = 1'b1;
                        state_d       = S_NEXT;
                    end else begin
                        ambig_d = ambig_q + 8'd1;
                        state_d = S_CLEAR;
                    end
                end else if (late) begin
                    ambig_d = '0;
                    if (tap_cur == MAX_TAP) begin
                        err_d[lane_q] = 1'b1;
                        state_d       = S_NEXT;
                    end else begin
                        dir_d[lane_q] = 1'b1;
                        state_d       = S_MOVE;
                    end
                end else begin
                    ambig_d = '0;
                    if (tap_cur == '0) begin
                        err_d[lane_q] = 1'b1;
                        state_d       = S_NEXT;
                    end else begin
                        dir_d[lane_q] = 1'b0;
                        state_d       = S_MOVE;
                    end
                end
            end
            S_MOVE: begin
                delay_line_move_o = lane_sel;
                // Saturating step keeps the tap count from ever wrapping
                if (dir_q[lane_q] && (tap_cur != MAX_TAP)) begin
                    tap_d[base +: TAP_W] = tap_cur + TAP_W'(1);
                end else if (!dir_q[lane_q] && (tap_cur != '0)) begin
                    tap_d[base +: TAP_W] = tap_cur - TAP_W'(1);
                end
                state_d = S_CLEAR;
            end
            S_NEXT: begin
                if (lane_q == LAST_LANE) begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lane_d  = lane_q + LW'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ddr_lane_dly_trainer.sv
// tb/tb_ddr_lane_dly_trainer.sv - scoreboard bench for ddr_lane_dly_trainer
module tb_ddr_lane_dly_trainer;

    localparam int LANES   = 2;
    localparam int TAP_W   = 8;
    localparam int SETTLE  = 4;
    localparam int MAXAMB  = 3;
    localparam int MAX_TAP = (1 << TAP_W) - 1;
    localparam int MEM_D   = 300;

    logic                   fab_clk_i = 1'b0;
    logic                   arst_n_i;
    logic                   start_i;
    logic [LANES-1:0]       early_i, late_i, oor_i;
    logic [LANES-1:0]       load_o, move_o, dir_o, clear_o;
    logic                   busy_o, done_o;
    logic [LANES-1:0]       locked_o, err_o;
    logic [LANES*TAP_W-1:0] tap_o;

    ddr_lane_dly_trainer #(
        .LANES(LANES), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE), .MAX_AMBIG(MAXAMB)
    ) dut (
        .fab_clk_i                 (fab_clk_i),
        .arst_n_i                  (arst_n_i),
        .start_i                   (start_i),
        .eye_monitor_early_i       (early_i),
        .eye_monitor_late_i        (late_i),
        .delay_line_out_of_range_i (oor_i),
        .delay_line_load_o         (load_o),
        .delay_line_move_o         (move_o),
        .delay_line_direction_o    (dir_o),
        .eye_monitor_clear_flags_o (clear_o),
        .busy_o                    (busy_o),
        .done_o                    (done_o),
        .lane_locked_o             (locked_o),
        .lane_err_o                (err_o),
        .tap_count_o               (tap_o)
    );

    always #5 fab_clk_i = ~fab_clk_i;

    typedef struct {
        int kind;   // 0 load, 1 move, 2 done
        int lane;
        int dir;
        logic [LANES-1:0]       locked;
        logic [LANES-1:0]       err;
        logic [LANES*TAP_W-1:0] taps;
        int total;
    } ev_t;

    ev_t        exp_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    bit         done_seen = 0;
    int         cur_lane = -1;
    int         idx[LANES];
    logic [2:0] rmem[LANES][MEM_D];   // bit0 early, bit1 late, bit2 out-of-range
    int         rlen[LANES];

    always @(posedge fab_clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int low_idx(input logic [LANES-1:0] v);
        for (int i = 0; i < LANES; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Monitor: pops one expectation per observed load/move/done event
    task automatic observe(input int kind, input int lane);
        ev_t e;
        if (exp_q.size() == 0) begin
            chk("unexpected_event_kind", 64'(kind), 64'hFF);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 64'(kind), 64'(e.kind));
        chk("event_lane", 64'(lane), 64'(e.lane));
        if (kind == 1 && e.kind == 1 && lane >= 0)
            chk("move_direction", 64'(dir_o[lane]), 64'(e.dir));
        if (kind == 2 && e.kind == 2) begin
            chk("done_locked", 64'(locked_o), 64'(e.locked));
            chk("done_err", 64'(err_o), 64'(e.err));
            chk("done_taps", 64'(tap_o), 64'(e.taps));
            chk("done_latency", 64'(cyc - acc_cyc + 1), 64'(e.total));
            chk("done_busy", 64'(busy_o), 64'd1);
            done_seen = 1;
        end
    endtask

    always @(negedge fab_clk_i) begin
        if (arst_n_i === 1'b1) begin
            if (load_o != '0) begin
                chk("load_onehot", 64'($onehot(load_o)), 64'd1);
                observe(0, low_idx(load_o));
            end
            if (move_o != '0) begin
                chk("move_onehot", 64'($onehot(move_o)), 64'd1);
                observe(1, low_idx(move_o));
            end
            if (clear_o != '0) chk("clear_onehot", 64'($onehot(clear_o)), 64'd1);
            if (done_o) observe(2, 0);
        end
    end

    // Eye-monitor model: each clear pulse on a lane advances that lane's response list
    always @(negedge fab_clk_i) begin
        logic [2:0] r;
        if (clear_o != '0) begin
            cur_lane = low_idx(clear_o);
            idx[cur_lane]++;
        end
        early_i = LANES'($urandom);
        late_i  = LANES'($urandom);
        oor_i   = LANES'($urandom);
        if (cur_lane >= 0) begin
            r = (idx[cur_lane] >= 0 && idx[cur_lane] < rlen[cur_lane]) ? rmem[cur_lane][idx[cur_lane]] : 3'b000;
            early_i[cur_lane] = r[0];
            late_i[cur_lane]  = r[1];
            oor_i[cur_lane]   = r[2];
        end
    end

    task automatic step;
        @(negedge fab_clk_i);
        #1;
    endtask

    task automatic clr_list(input int l);
        rlen[l] = 0;
    endtask

    task automatic add_resp(input int l, input logic [2:0] r, input int n);
        for (int i = 0; i < n; i++) begin
            rmem[l][rlen[l]] = r;
            rlen[l]++;
        end
    endtask

    task automatic rand_list(input int l);
        int n, w;
        clr_list(l);
        n = $urandom_range(0, 12);
        for (int i = 0; i < n; i++) begin
            w = $urandom_range(0, 99);
            if (w < 40)      add_resp(l, 3'b010, 1);
            else if (w < 65) add_resp(l, 3'b001, 1);
            else if (w < 88) add_resp(l, 3'b011, 1);
            else if (w < 94) add_resp(l, 3'(4 | $urandom_range(0, 3)), 1);
            else             add_resp(l, 3'b000, 1);
        end
    endtask

    // Reference model: walk each lane's responses with the training rules, push expectations
    task automatic build_expect(output int total, output logic [LANES-1:0] lk,
                                output logic [LANES-1:0] er, output logic [LANES*TAP_W-1:0] tp);
        ev_t e;
        total = 0; lk = '0; er = '0; tp = '0;
        for (int l = 0; l < LANES; l++) begin
            int tap = 0, amb = 0, mv = 0, rt = 0, k = 0;
            bit fin = 0;
            logic [2:0] r;
            e = '{kind: 0, lane: l, dir: 0, locked: '0, err: '0, taps: '0, total: 0};
            exp_q.push_back(e);
            while (!fin) begin
                r = (k < rlen[l]) ? rmem[l][k] : 3'b000;
                k++;
                if (r[2]) begin
                    er[l] = 1'b1; fin = 1;
                end else if (r[1:0] == 2'b00) begin
                    lk[l] = 1'b1; fin = 1;
                end else if (r[1:0] == 2'b11) begin
                    amb++;
                    if (amb >= MAXAMB) begin er[l] = 1'b1; fin = 1; end
                    else rt++;
                end else if (r[1]) begin
                    amb = 0;
                    if (tap == MAX_TAP) begin er[l] = 1'b1; fin = 1; end
                    else begin
                        tap++; mv++;
                        e = '{kind: 1, lane: l, dir: 1, locked: '0, err: '0, taps: '0, total: 0};
                        exp_q.push_back(e);
                    end
                end else begin
                    amb = 0;
                    if (tap == 0) begin er[l] = 1'b1; fin = 1; end
                    else begin
                        tap--; mv++;
                        e = '{kind: 1, lane: l, dir: 0, locked: '0, err: '0, taps: '0, total: 0};
                        exp_q.push_back(e);
                    end
                end
            end
            tp[l*TAP_W +: TAP_W] = TAP_W'(tap);
            total += (SETTLE + 4) + mv * (SETTLE + 3) + rt * (SETTLE + 2);
        end
        e = '{kind: 2, lane: 0, dir: 0, locked: lk, err: er, taps: tp, total: total};
        exp_q.push_back(e);
    endtask

    task automatic arm_env;
        cur_lane = -1;
        for (int l = 0; l < LANES; l++) idx[l] = -1;
        done_seen = 0;
    endtask

    task automatic run_training(input bit spurious);
        int total, sp;
        logic [LANES-1:0] lk, er;
        logic [LANES*TAP_W-1:0] tp;
        build_expect(total, lk, er, tp);
        arm_env();
        sp = $urandom_range(0, total - 2);
        start_i = 1'b1;
        acc_cyc = cyc + 1;
        step();
        start_i = 1'b0;
        for (int j = 0; j < total + 40 && !done_seen; j++) begin
            if (spurious && j == sp) start_i = 1'b1;
            step();
            start_i = 1'b0;
        end
        if (!done_seen) begin
            chk("done_timeout", 64'd0, 64'd1);
            exp_q.delete();
        end
        chk("events_consumed", 64'(exp_q.size()), 64'd0);
        step();
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_done", 64'(done_o), 64'd0);
        chk("hold_locked", 64'(locked_o), 64'(lk));
        chk("hold_err", 64'(err_o), 64'(er));
        chk("hold_taps", 64'(tap_o), 64'(tp));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_done"}, 64'(done_o), 64'd0);
        chk({tag, "_pulses"}, 64'({load_o, move_o, clear_o}), 64'd0);
        chk({tag, "_dir"}, 64'(dir_o), 64'd0);
        chk({tag, "_locked_err"}, 64'({locked_o, err_o}), 64'd0);
        chk({tag, "_taps"}, 64'(tap_o), 64'd0);
    endtask

    task automatic reset_mid_lane1;
        int n;
        clr_list(0); add_resp(0, 3'b010, 2);
        clr_list(1); add_resp(1, 3'b010, 3);
        begin
            int total;
            logic [LANES-1:0] lk, er;
            logic [LANES*TAP_W-1:0] tp;
            build_expect(total, lk, er, tp);
        end
        arm_env();
        start_i = 1'b1;
        acc_cyc = cyc + 1;
        step();
        start_i = 1'b0;
        n = 0;
        while (clear_o[1] !== 1'b1 && n < 200) begin step(); n++; end
        chk("reach_lane1_clear", 64'(clear_o[1]), 64'd1);
        step(); step();
        #1 arst_n_i = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        arm_env();
        step();
        step();
        arst_n_i = 1'b1;
        step();
        check_all_zero("post_release");
        run_training(0);
    endtask

    initial begin
        arst_n_i = 1'b0;
        start_i  = 1'b0;
        early_i  = '0;
        late_i   = '0;
        oor_i    = '0;
        for (int l = 0; l < LANES; l++) begin rlen[l] = 0; idx[l] = -1; end
        step(); step();
        check_all_zero("reset");
        arst_n_i = 1'b1;
        step();

        // All lanes centred immediately: 16-cycle run, both locked at tap 0
        clr_list(0); clr_list(1);
        run_training(0);
        // Lane 0 late five times then centred
        clr_list(0); add_resp(0, 3'b010, 5); clr_list(1);
        run_training(0);
        // Lane 1 early at tap 0
        clr_list(0); clr_list(1); add_resp(1, 3'b001, 1);
        run_training(0);
        // Lane 0 ambiguous three times in a row
        clr_list(0); add_resp(0, 3'b011, 3); clr_list(1);
        run_training(0);
        // Ambiguity counter reset by a directional sample
        clr_list(0); add_resp(0, 3'b011, 2); add_resp(0, 3'b010, 1); add_resp(0, 3'b011, 2);
        clr_list(1); add_resp(1, 3'b011, 2);
        run_training(0);
        // Out-of-range with late wins; START while busy ignored
        clr_list(0); add_resp(0, 3'b110, 1); clr_list(1); add_resp(1, 3'b010, 2);
        run_training(1);
        // Upper tap limit on lane 0, walk back below zero on lane 1
        clr_list(0); add_resp(0, 3'b010, MAX_TAP + 1);
        clr_list(1); add_resp(1, 3'b010, 3); add_resp(1, 3'b001, 5);
        run_training(0);
        // Asynchronous reset during lane 1 settle, then a full retrain
        reset_mid_lane1();
        // Randomized lanes
        for (int t = 0; t < 25; t++) begin
            for (int l = 0; l < LANES; l++) rand_list(l);
            run_training(($urandom_range(0, 1)) == 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ddr_lane_dly_trainer.md
DDR_LANE_DLY_TRAINER -- requirements
Module: ddr_lane_dly_trainer

Interface
REQ-001 The block SHALL use one clock and a reset that is asynchronous and active-low.
REQ-002 Parameter LANES, default 2, SHALL set the number of DQ/DQS lanes served (1..8).
REQ-003 Parameter TAP_W, default 8, SHALL set the delay-tap counter width; MAX_TAP = 2**TAP_W-1.
REQ-004 Parameter SETTLE_CYCLES, default 4, SHALL set the wait after clearing flags before sampling (1..255).
REQ-005 Parameter MAX_AMBIG, default 3, SHALL set the number of consecutive early-and-late samples tolerated per lane.
REQ-006 FAB_CLK  in  1  fabric clock; all logic is rising-edge.
REQ-007 ARST_N  in  1  asynchronous active-low reset.
REQ-008 START  in  1  single-cycle training request.
REQ-009 EYE_MONITOR_EARLY  in  LANES  per-lane early flag.
REQ-010 EYE_MONITOR_LATE  in  LANES  per-lane late flag.
REQ-011 DELAY_LINE_OUT_OF_RANGE  in  LANES  per-lane out-of-range flag.
REQ-012 DELAY_LINE_LOAD  out  LANES  per-lane delay-line load pulse.
REQ-013 DELAY_LINE_MOVE  out  LANES  per-lane one-tap move pulse.
REQ-014 DELAY_LINE_DIRECTION  out  LANES  per-lane direction, 1 = increase delay.
REQ-015 EYE_MONITOR_CLEAR_FLAGS  out  LANES  per-lane flag clear pulse.
REQ-016 BUSY  out  1  training in progress.
REQ-017 DONE  out  1  single-cycle pulse when all lanes have finished.
REQ-018 LANE_LOCKED  out  LANES  lane centred.
REQ-019 LANE_ERR  out  LANES  lane failed.
REQ-020 TAP_COUNT  out  LANES*TAP_W  per-lane tap position; lane i occupies bits [i*TAP_W +: TAP_W].

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, CLEAR, SETTLE, SAMPLE, MOVE, NEXT; one shared FSM with lane index L serves the lanes sequentially from 0 to LANES-1.
REQ-022 In IDLE, START=1 SHALL clear LANE_LOCKED, LANE_ERR and TAP_COUNT, set L=0 and enter LOAD; while BUSY=1, START SHALL be ignored.
REQ-023 LOAD (1 cycle) SHALL pulse DELAY_LINE_LOAD[L], set TAP_COUNT[L]=0 and the ambiguity counter to 0, then enter CLEAR.
REQ-024 CLEAR (1 cycle) SHALL pulse EYE_MONITOR_CLEAR_FLAGS[L], then enter SETTLE.
REQ-025 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE.
REQ-026 SAMPLE (1 cycle) SHALL decide on EARLY[L], LATE[L] and OUT_OF_RANGE[L], with priority in the order of REQ-027 to REQ-031.
REQ-027 If OUT_OF_RANGE[L]=1, SAMPLE SHALL set LANE_ERR[L] and enter NEXT.
REQ-028 If early=0 and late=0, SAMPLE SHALL set LANE_LOCKED[L] and enter NEXT.
REQ-029 If early=1 and late=1, SAMPLE SHALL increment the ambiguity counter and enter CLEAR without moving; when the counter reaches MAX_AMBIG it SHALL instead set LANE_ERR[L] and enter NEXT.
REQ-030 If late only, SAMPLE SHALL set DIRECTION[L]=1 and enter MOVE; at TAP_COUNT[L]=MAX_TAP it SHALL set LANE_ERR[L] and enter NEXT instead.
REQ-031 If early only, SAMPLE SHALL set DIRECTION[L]=0 and enter MOVE; at TAP_COUNT[L]=0 it SHALL set LANE_ERR[L] and enter NEXT instead.
REQ-032 Any early-only or late-only sample SHALL reset the ambiguity counter to 0.
REQ-033 MOVE (1 cycle) SHALL pulse DELAY_LINE_MOVE[L], apply +1/-1 to TAP_COUNT[L] per DIRECTION[L], then enter CLEAR; TAP_COUNT SHALL never wrap.
REQ-034 DIRECTION[L] SHALL be stable from SAMPLE through the MOVE cycle.
REQ-035 NEXT (1 cycle) SHALL increment L and enter LOAD; if L=LANES-1 it SHALL pulse DONE and enter IDLE.
REQ-036 BUSY SHALL be 1 in every state except IDLE.
REQ-037 Only bit L of each per-lane pulse output SHALL ever be 1; pulses SHALL be exactly one cycle wide.
REQ-038 LANE_LOCKED[i] and LANE_ERR[i] SHALL be mutually exclusive and SHALL hold until the next accepted START.
REQ-039 The zero-move latency per lane SHALL be SETTLE_CYCLES+4 cycles (LOAD, CLEAR, SETTLE, SAMPLE, NEXT); each tap move SHALL add SETTLE_CYCLES+3 cycles.

Reset
REQ-040 With ARST_N=0, the block SHALL asynchronously enter IDLE and drive every output to 0: all pulses, DIRECTION, BUSY, DONE, LANE_LOCKED, LANE_ERR and TAP_COUNT.
REQ-041 When reset is asserted mid-training, all partial results SHALL be discarded, and no pulse SHALL be issued in the first cycle after release.

Verification
REQ-042 LANES=2, SETTLE_CYCLES=4, both flags 0 -> START; DONE is pulsed 16 cycles later, LANE_LOCKED=2'b11 and TAP_COUNT=0.
REQ-043 Lane 0 late for 5 samples, then clear -> 5 MOVE pulses with DIRECTION[0]=1, TAP_COUNT[0]=5, LANE_LOCKED[0]=1.
REQ-044 Lane 1 early at tap 0 -> no MOVE pulse, LANE_ERR[1]=1, LANE_LOCKED[1]=0, DONE still pulses.
REQ-045 Lane 0 early and late for 3 samples -> LANE_ERR[0]=1 after the third sample, TAP_COUNT[0]=0, training continues with lane 1.
REQ-046 OUT_OF_RANGE[0]=1 together with late -> LANE_ERR[0]=1 and no move issued; START while BUSY has no effect.
REQ-047 ARST_N pulsed low during lane 1 SETTLE -> all outputs 0 at once; a new START retrains both lanes from tap 0.
